// File: rtl/shifter_spi_master.sv
// shifter_spi_master
//   Processor-side SPI master that offloads a shift/rotate to the barrel
//   shifter slave. A request (op code, operand, shift amount) is accepted on
//   a valid/ready handshake and sent LSB first as a ShifterPacket on MOSI,
//   preceded by one select cycle and a start bit. The master then waits for
//   the slave's miso=1 marker, shifts in the REGISTER_SIZE-bit result, and
//   presents it with a one-cycle o_done pulse.
//
//   Ports
//     i_clock         system clock (the only clock)
//     i_reset         synchronous, active-low reset
//     i_valid/o_ready request handshake; o_ready is high only in IDLE
//     i_op_code       shifter operation (Isa::Operation)
//     i_operand       value to shift
//     i_shift_amount  shift distance
//     o_done          one-cycle pulse when o_result (or o_error) is valid
//     o_result        last received result, held until the next DONE
//     o_error         WAIT_ACK timeout flag (constant 0 unless enabled)
//     spi             Spi.MasterSpi: drives nss and mosi, samples miso
//
//   Optional feature macro: SHIFTER_MASTER_TIMEOUT_EN
//     When defined, WAIT_ACK gives up after TimeoutCycles cycles without the
//     marker: nss is released, o_done pulses with o_error=1, o_result is kept.

package Isa;
  parameter int REGISTER_SIZE = 8;

  typedef enum logic [2:0] {
    SHL = 3'd0,
    SHR = 3'd1,
    SAR = 3'd2
  } Operation;

  // Field order fixes the wire order: op_code occupies the LSBs and is sent first.
  typedef struct packed {
    logic [$clog2(REGISTER_SIZE)-1:0] shift_amount;
    logic [REGISTER_SIZE-1:0]         operand;
    Operation                         op_code;
  } ShifterPacket;
endpackage

interface Spi #(parameter int NssWidth = 1) ();
  logic [NssWidth-1:0] nss;
  logic                mosi;
  logic                miso;

  modport MasterSpi (output nss, output mosi, input miso);
  modport SlaveSpi  (input nss, input mosi, output miso);
endinterface

module shifter_spi_master
  import Isa::*;
#(
  parameter int NssPosition   = 0,
  parameter int NssWidth      = 1,
  parameter int TimeoutCycles = 64
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  Operation                         i_op_code,
  input  logic [REGISTER_SIZE-1:0]         i_operand,
  input  logic [$clog2(REGISTER_SIZE)-1:0] i_shift_amount,
  output logic                             o_done,
  output logic [REGISTER_SIZE-1:0]         o_result,
  output logic                             o_error,
  Spi.MasterSpi                            spi
);

  localparam int PACKET_BITS = $bits(ShifterPacket);
  localparam int CNT_W       = $clog2(PACKET_BITS + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SELECT, ST_START, ST_TX, ST_WAIT_ACK, ST_RX, ST_DONE
  } state_t;

  state_t                   state_reg, state_next;
  logic [CNT_W-1:0]         bit_cnt_reg, bit_cnt_next;
  logic [PACKET_BITS-1:0]   packet_reg, packet_next;
  logic [REGISTER_SIZE-1:0] rx_reg, rx_next;
  logic [REGISTER_SIZE-1:0] result_reg, result_next;
  logic                     ready_reg, ready_next;
  logic                     done_reg, done_next;
  logic                     mosi_reg, mosi_next;
  logic                     sel_n_reg, sel_n_next;
  ShifterPacket             pkt_in;

`ifdef SHIFTER_MASTER_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TimeoutCycles + 1);
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              error_reg, error_next;
`endif

  // Reject parameter sets that would select a nonexistent nss bit or never time out.
  if (NssPosition < 0 || NssPosition >= NssWidth || TimeoutCycles < 1) begin : g_param_check
    $error("shifter_spi_master: illegal NssPosition/NssWidth/TimeoutCycles");
  end

  assign pkt_in = '{shift_amount: i_shift_amount, operand: i_operand, op_code: i_op_code};

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    packet_next  = packet_reg;
    rx_next      = rx_reg;
    result_next  = result_reg;
    done_next    = 1'b0;
    mosi_next    = 1'b0;
    ready_next   = 1'b0;
    sel_n_next   = 1'b1;
`ifdef SHIFTER_MASTER_TIMEOUT_EN
    wait_cnt_next = wait_cnt_reg;
    error_next    = error_reg;
`endif

    // Output registers are loaded with the values belonging to state_next,
    // so every output is a flop yet lines up with the state it describes.
    case (state_reg)
      ST_IDLE: begin
        if (i_valid && ready_reg) begin
          packet_next = pkt_in;
          state_next  = ST_SELECT;
`ifdef SHIFTER_MASTER_TIMEOUT_EN
          error_next  = 1'b0;
`endif
        end
      end
      ST_SELECT: begin
        state_next = ST_START;
        mosi_next  = 1'b1;
      end
      ST_START: begin
        state_next   = ST_TX;
        bit_cnt_next = '0;
        mosi_next    = packet_reg[0];
        packet_next  = packet_reg >> 1;
      end
      ST_TX: begin
        // packet_reg is consumed from the LSB, so mosi always equals packet[bit_cnt].
        if (bit_cnt_reg == CNT_W'(PACKET_BITS - 1)) begin
          state_next   = ST_WAIT_ACK;
          bit_cnt_next = '0;
`ifdef SHIFTER_MASTER_TIMEOUT_EN
          wait_cnt_next = '0;
`endif
        end else begin
          bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          mosi_next    = packet_reg[0];
          packet_next  = packet_reg >> 1;
        end
      end
      ST_WAIT_ACK: begin
        // Only a solid 1 is the marker; x/z falls through to the else branch.
        if (spi.miso == 1'b1) begin
          state_next   = ST_RX;
          bit_cnt_next = '0;
        end
`ifdef SHIFTER_MASTER_TIMEOUT_EN
        else if (wait_cnt_reg == WAIT_W'(TimeoutCycles - 1)) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
          error_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
`endif
      end
      ST_RX: begin
        // Result arrives LSB first; shifting in at the MSB leaves bit 0 at the bottom.
        rx_next = {spi.miso, rx_reg[REGISTER_SIZE-1:1]};
        if (bit_cnt_reg == CNT_W'(REGISTER_SIZE - 1)) begin
          state_next   = ST_DONE;
          bit_cnt_next = '0;
          result_next  = rx_next;
          done_next    = 1'b1;
        end else begin
          bit_cnt_next = bit_cnt_reg + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    ready_next = (state_next == ST_IDLE);
    sel_n_next = (state_next == ST_IDLE) || (state_next == ST_DONE);
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= '0;
      packet_reg  <= '0;
      rx_reg      <= '0;
      result_reg  <= '0;
      ready_reg   <= 1'b1;
      done_reg    <= 1'b0;
      mosi_reg    <= 1'b0;
      sel_n_reg   <= 1'b1;
`ifdef SHIFTER_MASTER_TIMEOUT_EN
      wait_cnt_reg <= '0;
      error_reg    <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      packet_reg  <= packet_next;
      rx_reg      <= rx_next;
      result_reg  <= result_next;
      ready_reg   <= ready_next;
      done_reg    <= done_next;
      mosi_reg    <= mosi_next;
      sel_n_reg   <= sel_n_next;
`ifdef SHIFTER_MASTER_TIMEOUT_EN
      wait_cnt_reg <= wait_cnt_next;
      error_reg    <= error_next;
`endif
    end
  end

  // Only the selected slave's nss bit toggles; all others stay deasserted.
  genvar gi;
  for (gi = 0; gi < NssWidth; gi++) begin : g_nss
    if (gi == NssPosition) begin : g_sel
      assign spi.nss[gi] = sel_n_reg;
    end else begin : g_other
      assign spi.nss[gi] = 1'b1;
    end
  end

  assign spi.mosi = mosi_reg;
  assign o_ready  = ready_reg;
  assign o_done   = done_reg;
  assign o_result = result_reg;
`ifdef SHIFTER_MASTER_TIMEOUT_EN
  assign o_error  = error_reg;
`else
  assign o_error  = 1'b0;
`endif

endmodule

// File: tb/tb_shifter_spi_master.sv
// Directed bench for shifter_spi_master with a behavioural barrel-shifter
// slave. The slave's SHL/SHR are circular (rotate) operations.
module tb_shifter_spi_master;
  import Isa::*;

  logic       i_clock;
  logic       i_reset;
  logic       i_valid;
  logic       o_ready;
  Operation   i_op_code;
  logic [7:0] i_operand;
  logic [2:0] i_shift_amount;
  logic       o_done;
  logic [7:0] o_result;
  logic       o_error;

  Spi #(.NssWidth(1)) spi_bus ();

  shifter_spi_master #(
    .NssPosition(0), .NssWidth(1), .TimeoutCycles(64)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_op_code(i_op_code), .i_operand(i_operand), .i_shift_amount(i_shift_amount),
    .o_done(o_done), .o_result(o_result), .o_error(o_error), .spi(spi_bus)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- behavioural slave ----------------
  typedef enum int {S_IDLE, S_PKT, S_COMP, S_SEND, S_END} slave_st_t;
  slave_st_t   s_state;
  logic [13:0] s_pkt;
  logic [7:0]  s_res;
  int          s_cnt;
  int          ack_wait = 2;        // WAIT_ACK cycles the master will see
  int          mosi_wait_hits = 0;  // mosi=1 seen while master waits/receives
  int          accept_cnt = 0;

  function automatic logic [7:0] slave_compute(input logic [13:0] pkt);
    logic [7:0] v;
    int         sh;
    v  = pkt[10:3];
    sh = int'(pkt[13:11]);
    if (pkt[2:0] == SHL) return (v << sh) | (v >> (8 - sh));
    if (pkt[2:0] == SHR) return (v >> sh) | (v << (8 - sh));
    return v;
  endfunction

  always @(posedge i_clock) begin
    if (!i_reset || spi_bus.nss[0]) begin
      s_state      <= S_IDLE;
      s_cnt        <= 0;
      spi_bus.miso <= 1'b0;
    end else begin
      case (s_state)
        S_IDLE: if (spi_bus.mosi) s_state <= S_PKT;
        S_PKT: begin
          s_pkt[s_cnt] <= spi_bus.mosi;
          if (s_cnt == 13) begin
            s_state <= S_COMP;
            s_cnt   <= 1;
          end else s_cnt <= s_cnt + 1;
        end
        S_COMP: begin
          if (spi_bus.mosi) mosi_wait_hits <= mosi_wait_hits + 1;
          if (s_cnt >= ack_wait - 1) begin
            spi_bus.miso <= 1'b1;
            s_res        <= slave_compute(s_pkt);
            s_state      <= S_SEND;
            s_cnt        <= 0;
          end else s_cnt <= s_cnt + 1;
        end
        S_SEND: begin
          if (spi_bus.mosi) mosi_wait_hits <= mosi_wait_hits + 1;
          if (s_cnt == 8) begin
            spi_bus.miso <= 1'b0;
            s_state      <= S_END;
          end else begin
            spi_bus.miso <= s_res[s_cnt];
            s_cnt        <= s_cnt + 1;
          end
        end
        default: ;
      endcase
    end
  end

  always @(posedge i_clock)
    if (i_reset && i_valid && o_ready) accept_cnt <= accept_cnt + 1;

  // Counts cycles after the accept edge until o_done; caller is at cycle 1.
  task automatic wait_done(input string tag, output int lat);
    lat = 1;
    while (!o_done && lat < 400) begin
      @(negedge i_clock);
      lat++;
    end
    check({tag, " done_seen"}, o_done, 1);
  endtask

  task automatic accept(input Operation op, input logic [7:0] opnd, input logic [2:0] sh);
    int n = 0;
    while (!o_ready && n < 200) begin
      @(negedge i_clock);
      n++;
    end
    i_op_code = op; i_operand = opnd; i_shift_amount = sh; i_valid = 1'b1;
    @(posedge i_clock);
    @(negedge i_clock);
    i_valid = 1'b0;
  endtask

  task automatic run_req(input Operation op, input logic [7:0] opnd, input logic [2:0] sh,
                         input int wait_cycles, input logic [7:0] exp_res,
                         input int exp_lat, input string tag);
    int lat;
    int hits0;
    ack_wait = wait_cycles;
    hits0 = mosi_wait_hits;
    accept(op, opnd, sh);
    check({tag, " ready_busy"}, o_ready, 0);
    check({tag, " nss_sel"}, spi_bus.nss[0], 0);
    wait_done(tag, lat);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, o_result, exp_res);
    check({tag, " error"}, o_error, 0);
    @(negedge i_clock);
    check({tag, " done_pulse"}, o_done, 0);
    check({tag, " ready_back"}, o_ready, 1);
    check({tag, " mosi_quiet"}, mosi_wait_hits - hits0, 0);
    $display("req %s: op=%0d opnd=0x%02h sh=%0d -> result=0x%02h latency=%0d",
             tag, op, opnd, sh, o_result, lat);
  endtask

  task automatic check_idle(input string tag, input logic [7:0] exp_res);
    check({tag, " nss"}, spi_bus.nss[0], 1);
    check({tag, " mosi"}, spi_bus.mosi, 0);
    check({tag, " ready"}, o_ready, 1);
    check({tag, " done"}, o_done, 0);
    check({tag, " result"}, o_result, exp_res);
    check({tag, " error"}, o_error, 0);
  endtask

  initial begin
    int lat;
    int acc0;
    int done_hits;
    logic [13:0] exp_pkt;

    i_reset = 1'b0; i_valid = 1'b0;
    i_op_code = SHL; i_operand = 8'h00; i_shift_amount = 3'd0;
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    check_idle("reset", 8'h00);
    i_reset = 1'b1;
    @(negedge i_clock);

    // Basic transfers
    run_req(SHL, 8'h81, 3'd1, 2, 8'h03, 27, "shl_81_1");
    run_req(SHR, 8'h01, 3'd3, 2, 8'h20, 27, "shr_01_3");
    exp_pkt = {3'd3, 8'h01, SHR};
    check("shr mosi_stream", s_pkt, exp_pkt);

    // Second request held on i_valid during a transfer
    acc0 = accept_cnt;
    ack_wait = 2;
    accept(SHL, 8'h0F, 3'd2);
    i_op_code = SHR; i_operand = 8'hA5; i_shift_amount = 3'd4; i_valid = 1'b1;
    wait_done("held_a", lat);
    check("held_a latency", lat, 27);
    check("held_a result", o_result, 8'h3C);
    @(negedge i_clock);
    check("held idle_ready", o_ready, 1);
    @(posedge i_clock);
    @(negedge i_clock);
    i_valid = 1'b0;
    wait_done("held_b", lat);
    check("held_b latency", lat, 27);
    check("held_b result", o_result, 8'h5A);
    check("held accepts", accept_cnt - acc0, 2);
    @(negedge i_clock);
    $display("req held: results 0x3c then 0x%02h, accepts=%0d", o_result, accept_cnt - acc0);

    // Slow acknowledge: 20 WAIT_ACK cycles
    run_req(SHL, 8'hF0, 3'd7, 20, 8'h78, 45, "slow_ack");

    // Reset held 3 cycles in the middle of TX
    accept(SHR, 8'h81, 3'd3);
    repeat (6) @(negedge i_clock);
    i_reset = 1'b0;
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b1;
    @(posedge i_clock);
    @(negedge i_clock);
    check_idle("mid_tx_reset", 8'h00);
    $display("reset mid-TX: nss=%b mosi=%b ready=%b result=0x%02h",
             spi_bus.nss, spi_bus.mosi, o_ready, o_result);

    run_req(SHL, 8'h12, 3'd4, 2, 8'h21, 27, "after_reset");

`ifdef SHIFTER_MASTER_TIMEOUT_EN
    // Slave never acknowledges: timeout after 64 WAIT_ACK cycles
    ack_wait = 100000;
    accept(SHR, 8'h44, 3'd1);
    wait_done("timeout", lat);
    check("timeout latency", lat, 81);
    check("timeout error", o_error, 1);
    check("timeout nss", spi_bus.nss[0], 1);
    check("timeout result", o_result, 8'h21);
    @(negedge i_clock);
    check("timeout done_pulse", o_done, 0);
    $display("req timeout: latency=%0d error=%b result=0x%02h", lat, o_error, o_result);
    run_req(SHR, 8'h44, 3'd1, 2, 8'h22, 27, "after_timeout");
`else
    // Slave never acknowledges: the master waits indefinitely
    ack_wait = 100000;
    accept(SHR, 8'h44, 3'd1);
    done_hits = 0;
    repeat (120) begin
      @(negedge i_clock);
      if (o_done) done_hits++;
    end
    check("no_ack done_count", done_hits, 0);
    check("no_ack nss", spi_bus.nss[0], 0);
    check("no_ack ready", o_ready, 0);
    check("no_ack error", o_error, 0);
    $display("req no_ack: done_count=%0d nss=%b ready=%b", done_hits, spi_bus.nss, o_ready);
    i_reset = 1'b0;
    repeat (2) @(posedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b1;
    @(negedge i_clock);
    check_idle("no_ack_reset", 8'h00);
    run_req(SHR, 8'h44, 3'd1, 2, 8'h22, 27, "after_no_ack");
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
